// File: rtl/quantizer_pipe.sv
// quantizer_pipe: pipelined coefficient quantizer (reciprocal multiply, round
// half away from zero, symmetric saturation) with runtime-loadable per-block
// reciprocal tables and a valid/ready handshake with a global stall.
module quantizer_pipe #(
    parameter int IN_W       = 15,
    parameter int OUT_W      = 11,
    parameter int RECIP_W    = 16,
    parameter int SHIFT      = 16,
    parameter int BLK_LEN    = 64,
    parameter int NUM_TABLES = 2,
    localparam int IDX_W     = $clog2(BLK_LEN),
    localparam int SEL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena_in,
    output logic                     rdy_out,
    input  logic signed [IN_W-1:0]   in,
    input  logic [SEL_W-1:0]         tbl_sel,
    output logic                     ena_out,
    input  logic                     rdy_in,
    output logic signed [OUT_W-1:0]  out,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    input  logic                     tbl_we,
    input  logic [SEL_W+IDX_W-1:0]   tbl_waddr,
    input  logic [RECIP_W-1:0]       tbl_wdata
);

    localparam int AW    = SEL_W + IDX_W;
    localparam int DEPTH = NUM_TABLES * BLK_LEN;
    localparam int P_W   = IN_W + RECIP_W;

    localparam logic [P_W:0]       HALF     = (P_W+1)'(1) << (SHIFT-1);
    localparam logic [P_W:0]       QMAX_W   = (P_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic [OUT_W-1:0]   QMAX     = OUT_W'((1 << (OUT_W-1)) - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(BLK_LEN - 1);

    logic               adv;
    logic               accept;
    logic [IDX_W-1:0]   idx;
    logic [SEL_W-1:0]   cur_sel;
    logic [SEL_W-1:0]   sel_now;

    // Accept stage: captured input plus the table address it will read.
    logic               s0_v;
    logic [IN_W-1:0]    s0_in;
    logic [IDX_W-1:0]   s0_idx;
    logic [AW-1:0]      s0_addr;

    logic [RECIP_W-1:0] mem [DEPTH];

    logic               s1_v;
    logic [IN_W-1:0]    s1_in;
    logic [IDX_W-1:0]   s1_idx;
    logic [RECIP_W-1:0] s1_r;

    logic               s2_v;
    logic               s2_sign;
    logic [IDX_W-1:0]   s2_idx;
    logic [P_W-1:0]     s2_prod;

    logic [IN_W-1:0]    mag;
    logic [P_W:0]       rnd;
    logic [P_W:0]       q_full;
    logic [OUT_W-1:0]   q_sat;
    logic [OUT_W-1:0]   q_signed;

    assign adv     = !ena_out || rdy_in;
    assign rdy_out = adv;
    assign accept  = ena_in && adv;
    assign sel_now = (idx == '0) ? tbl_sel : cur_sel;

    // Block index counter and per-block table selection latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            cur_sel <= '0;
        end else if (accept) begin
            idx <= idx + 1'b1;
            if (idx == '0) begin
                cur_sel <= tbl_sel;
            end
        end
    end

    // Accept stage: register the coefficient, its index and table address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_v    <= 1'b0;
            s0_in   <= '0;
            s0_idx  <= '0;
            s0_addr <= '0;
        end else if (adv) begin
            s0_v    <= accept;
            s0_in   <= in;
            s0_idx  <= idx;
            s0_addr <= {sel_now, idx};
        end
    end

    // Table write port; contents are not reset and writes ignore the stall.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            mem[tbl_waddr] <= tbl_wdata;
        end
    end

    // Synchronous table read; same-edge write to the address returns old data.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_r <= mem[s0_addr];
        end
    end

    // S1 control/data alongside the registered table read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v   <= 1'b0;
            s1_in  <= '0;
            s1_idx <= '0;
        end else if (adv) begin
            s1_v   <= s0_v;
            s1_in  <= s0_in;
            s1_idx <= s0_idx;
        end
    end

    // Magnitude as IN_W-bit unsigned so the most negative input stays exact.
    always_comb begin
        mag = s1_in[IN_W-1] ? (~s1_in + 1'b1) : s1_in;
    end

    // S2: sign and unsigned magnitude-times-reciprocal product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v    <= 1'b0;
            s2_sign <= 1'b0;
            s2_idx  <= '0;
            s2_prod <= '0;
        end else if (adv) begin
            s2_v    <= s1_v;
            s2_sign <= s1_in[IN_W-1];
            s2_idx  <= s1_idx;
            s2_prod <= P_W'(mag) * P_W'(s1_r);
        end
    end

    // Rounding on the magnitude gives half-away-from-zero; negating a zero
    // magnitude yields zero, so there is no negative zero.
    always_comb begin
        rnd      = {1'b0, s2_prod} + HALF;
        q_full   = rnd >> SHIFT;
        q_sat    = (q_full > QMAX_W) ? QMAX : q_full[OUT_W-1:0];
        q_signed = s2_sign ? (~q_sat + 1'b1) : q_sat;
    end

    // S3: output register, held while the downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ena_out  <= 1'b0;
            out      <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else if (adv) begin
            ena_out  <= s2_v;
            out      <= q_signed;
            out_idx  <= s2_idx;
            out_last <= s2_v && (s2_idx == IDX_LAST);
        end
    end

endmodule

// File: tb/tb_quantizer_pipe.sv
// tb_quantizer_pipe: directed and randomized checks of quantizer_pipe against
// an arithmetic reference model with a shadow copy of the reciprocal tables.
module tb_quantizer_pipe;

    localparam int IN_W       = 15;
    localparam int OUT_W      = 11;
    localparam int RECIP_W    = 16;
    localparam int SHIFT      = 16;
    localparam int BLK_LEN    = 64;
    localparam int NUM_TABLES = 2;
    localparam int IDX_W      = 6;
    localparam int SEL_W      = 1;
    localparam int QLIM       = (1 << (OUT_W-1)) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    ena_in = 1'b0;
    logic                    rdy_in = 1'b1;
    logic                    tbl_we = 1'b0;
    logic                    rdy_out;
    logic                    ena_out;
    logic                    out_last;
    logic signed [IN_W-1:0]  in = '0;
    logic [SEL_W-1:0]        tbl_sel = '0;
    logic signed [OUT_W-1:0] out;
    logic [IDX_W-1:0]        out_idx;
    logic [SEL_W+IDX_W-1:0]  tbl_waddr = '0;
    logic [RECIP_W-1:0]      tbl_wdata = '0;

    quantizer_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .RECIP_W(RECIP_W), .SHIFT(SHIFT),
        .BLK_LEN(BLK_LEN), .NUM_TABLES(NUM_TABLES)
    ) dut (
        .clk(clk), .rst(rst), .ena_in(ena_in), .rdy_out(rdy_out), .in(in),
        .tbl_sel(tbl_sel), .ena_out(ena_out), .rdy_in(rdy_in), .out(out),
        .out_idx(out_idx), .out_last(out_last), .tbl_we(tbl_we),
        .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int idx; bit last; } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned tbl_m [NUM_TABLES*BLK_LEN];
    int          m_idx = 0;
    int          m_sel = 0;
    int          mon_s;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_out = 0;
    bit          mon_en = 0;
    bit          rand_bp = 0;
    bit          snd_done = 0;
    bit          hold_v = 0;
    int          held_out;
    int          held_idx;
    bit          held_last;
    int          exp_v;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Quantize by the rules: |x|*R rounded half up, clamped, sign reapplied.
    function automatic int quant(input int x, input int unsigned r);
        longint mg;
        longint qv;
        mg = (x < 0) ? -longint'(x) : longint'(x);
        qv = (mg * longint'(r) + (longint'(1) << (SHIFT-1))) / (longint'(1) << SHIFT);
        if (qv > QLIM) qv = QLIM;
        return (x < 0) ? -int'(qv) : int'(qv);
    endfunction

    // Mid-cycle monitor: predicts transfers that will occur at the next edge.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            check_val("rdy_out", rdy_out, longint'(!ena_out || rdy_in));
            if (ena_out && !rdy_in) begin
                if (hold_v) begin
                    check_val("hold_out", int'(out), held_out);
                    check_val("hold_idx", out_idx, held_idx);
                    check_val("hold_last", out_last, held_last);
                end
                hold_v    = 1;
                held_out  = int'(out);
                held_idx  = int'(out_idx);
                held_last = out_last;
            end else begin
                hold_v = 0;
            end
            if (ena_out && rdy_in) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("out", int'(out), mon_e.val);
                    check_val("out_idx", out_idx, mon_e.idx);
                    check_val("out_last", out_last, mon_e.last);
                end
                n_out++;
            end
            if (ena_in && rdy_out) begin
                mon_s = (m_idx == 0) ? int'(tbl_sel) : m_sel;
                if (m_idx == 0) m_sel = mon_s;
                mon_e.val  = quant(int'(in), tbl_m[mon_s*BLK_LEN + m_idx]);
                mon_e.idx  = m_idx;
                mon_e.last = (m_idx == BLK_LEN-1);
                exp_q.push_back(mon_e);
                m_idx = (m_idx + 1) % BLK_LEN;
            end
            if (tbl_we) tbl_m[tbl_waddr] = tbl_wdata;
        end
    end

    // Random downstream backpressure.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            rdy_in = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int sel);
        bit acc;
        int budget;
        acc = 0;
        budget = 0;
        ena_in = 1'b1;
        in = IN_W'(x);
        tbl_sel = SEL_W'(sel);
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = rdy_out;
            @(posedge clk);
            #1;
            budget++;
        end
        ena_in = 1'b0;
        if (!acc) check_val("send_timeout", 0, 1);
    endtask

    task automatic wr(input int a, input int d);
        tbl_we = 1'b1;
        tbl_waddr = (SEL_W+IDX_W)'(a);
        tbl_wdata = RECIP_W'(d);
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || ena_out) && budget < 3000) begin
            tick();
            budget++;
        end
        check_val("drain_left", exp_q.size(), 0);
    endtask

    task automatic align();
        while (m_idx != 0) send(0, 0);
    endtask

    initial begin
        int base;
        int other;
        int vals[5] = '{1208, -1208, 8, -7, 0};

        // Reset state
        #1 rst = 1'b0;
        #1;
        check_val("rst_ena_out", ena_out, 0);
        check_val("rst_out", int'(out), 0);
        check_val("rst_out_idx", out_idx, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_rdy_out", rdy_out, 1);
        repeat (2) tick();
        rst = 1'b1;
        mon_en = 1;
        tick();

        for (int a = 0; a < BLK_LEN; a++) wr(a, 4096);
        for (int a = 0; a < BLK_LEN; a++) wr(BLK_LEN + a, 2048);

        // First-transaction latency: visible after the third edge past accept
        send(1200, 0);
        check_val("lat_e0", ena_out, 0);
        tick();
        check_val("lat_e1", ena_out, 0);
        tick();
        check_val("lat_e2", ena_out, 0);
        tick();
        check_val("lat_e3", ena_out, 1);
        check_val("lat_out", int'(out), 75);
        check_val("lat_idx", out_idx, 0);
        check_val("lat_last", out_last, 0);

        // Rounding and sign handling
        for (int i = 0; i < 5; i++) send(vals[i], 0);
        drain();

        // Saturation on both signs
        wr(0, 65535);
        wr(1, 65535);
        align();
        send(16383, 0);
        send(-16384, 0);
        drain();
        wr(0, 4096);
        wr(1, 4096);

        // Backpressure: downstream stalls for 5 cycles after the 2nd output
        base = n_out;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(16 * i, 0);
            end
            begin
                int budget;
                budget = 0;
                while (n_out < base + 2 && budget < 200) begin
                    tick();
                    budget++;
                end
                rdy_in = 1'b0;
                repeat (5) tick();
                rdy_in = 1'b1;
            end
        join
        drain();
        check_val("bp_count", n_out - base, 8);

        // Table 1 for a block, select toggling mid-block, then table 0
        align();
        for (int i = 0; i < BLK_LEN; i++) send(320, (i == 0) ? 1 : (i % 2));
        for (int i = 0; i < 4; i++) send(320, 0);
        align();
        drain();

        // Randomized traffic; each segment rewrites the table not in use
        rand_bp = 1;
        for (int seg = 0; seg < 4; seg++) begin
            other = 1 - (seg % 2);
            snd_done = 0;
            fork
                begin
                    for (int i = 0; i < 2*BLK_LEN; i++) begin
                        if ($urandom_range(0, 4) == 0) tick();
                        send(int'($urandom_range(0, 32767)) - 16384,
                             (m_idx == 0) ? (seg % 2) : int'($urandom_range(0, 1)));
                    end
                    snd_done = 1;
                end
                begin
                    while (!snd_done) begin
                        @(posedge clk);
                        #1;
                        if ($urandom_range(0, 3) == 0) begin
                            tbl_we = 1'b1;
                            tbl_waddr = {SEL_W'(other), IDX_W'($urandom_range(0, BLK_LEN-1))};
                            tbl_wdata = RECIP_W'($urandom);
                        end else begin
                            tbl_we = 1'b0;
                        end
                    end
                    tbl_we = 1'b0;
                end
            join
            drain();
        end
        rand_bp = 0;
        #2;
        rdy_in = 1'b1;
        tick();

        // Reset mid-stream with data in flight
        send(100, 0);
        send(200, 0);
        send(300, 0);
        send(400, 0);
        check_val("mid_ena_before", ena_out, 1);
        #1 rst = 1'b0;
        #1;
        check_val("mid_ena_out", ena_out, 0);
        check_val("mid_out", int'(out), 0);
        check_val("mid_out_last", out_last, 0);
        check_val("mid_rdy_out", rdy_out, 1);
        exp_q.delete();
        m_idx = 0;
        m_sel = 0;
        hold_v = 0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        exp_v = quant(1200, tbl_m[BLK_LEN]);
        send(1200, 1);
        repeat (3) tick();
        check_val("post_rst_ena", ena_out, 1);
        check_val("post_rst_idx", out_idx, 0);
        check_val("post_rst_out", int'(out), exp_v);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/quantizer_pipe.md
# quantizer_pipe

Parametrised, fully pipelined coefficient quantizer for the block-transform encoder path. It sits between the transform stage and the entropy-coding stage and replaces per-coefficient division with a reciprocal multiply, rounding and saturation. It quantizes one signed coefficient per cycle. Each coefficient uses its own entry from one of `NUM_TABLES` runtime-loadable reciprocal tables, selected per block. Both sides use a valid/ready handshake with full backpressure.

## Interface
- `IN_W`, 15, signed input coefficient width.
- `OUT_W`, 11, signed quantized output width.
- `RECIP_W`, 16, unsigned reciprocal table entry width.
- `SHIFT`, 16, right shift applied after multiply; an entry R represents 2^SHIFT/Q.
- `BLK_LEN`, 64, coefficients per block (power of 2); `IDX_W` = clog2(BLK_LEN).
- `NUM_TABLES`, 2, number of quantization tables (power of 2); `SEL_W` = max(1, clog2(NUM_TABLES)).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena_in`  in  1  upstream data valid.
- `rdy_out`  out  1  block can accept; input transfer occurs on an edge where `ena_in && rdy_out`.
- `in`  in  IN_W  signed coefficient.
- `tbl_sel`  in  SEL_W  table for the block; sampled only when accepting index 0.
- `ena_out`  out  1  output valid.
- `rdy_in`  in  1  downstream ready; output transfer occurs on an edge where `ena_out && rdy_in`.
- `out`  out  OUT_W  signed quantized coefficient.
- `out_idx`  out  IDX_W  in-block index of `out`.
- `out_last`  out  1  high with `ena_out` when `out_idx == BLK_LEN-1`.
- `tbl_we`  in  1  table write strobe.
- `tbl_waddr`  in  SEL_W+IDX_W  table write address, {table, index}.
- `tbl_wdata`  in  RECIP_W  reciprocal value.

## Operation
- Index counter `idx` counts accepted inputs and wraps from BLK_LEN-1 to 0.
- Table select:
  - An input accepted at `idx==0` uses `tbl_sel` directly and also latches it into `cur_sel`.
  - All other inputs use `cur_sel`.
  - Changes on `tbl_sel` mid-block are ignored.
- Table storage is an inferred RAM of NUM_TABLES*BLK_LEN x RECIP_W with one synchronous read and one write port.
  - The RAM is not reset; contents survive `rst`.
  - Read/write collision at the same address on the same edge returns the old data.
- Pipeline, with one valid bit per stage:
  - S1: register `in`, `idx`, and the RAM read at {sel, idx}.
  - S2: sign = in[IN_W-1]; mag = |in| (IN_W bits unsigned, so -2^(IN_W-1) is exact); register prod = mag*R (IN_W+RECIP_W bits).
  - S3: q = (prod + 2^(SHIFT-1)) >> SHIFT, i.e. round half away from zero; saturate q to 2^(OUT_W-1)-1; apply sign; register `out`, `out_idx`, `out_last`.
- Symmetric output range: the most negative output is -(2^(OUT_W-1)-1).
- Zero input gives zero output with no negative zero; R=0 gives 0.
- Global stall:
  - adv = !ena_out || rdy_in.
  - All stages, `idx` and `cur_sel` advance only when adv is high.
  - `rdy_out` = adv, a combinational path from `rdy_in` and `ena_out`.
- Bubbles propagate as invalid stages and are not compressed.
- Writes to the table are honoured at any time, including while stalled.
- Software must not rewrite an entry of the active table mid-block if it needs deterministic results.

## Timing
- Reset values, asserted asynchronously while `rst`=0:
  - `ena_out`=0, `out`=0, `out_idx`=0, `out_last`=0.
  - All stage valids 0, `idx`=0, `cur_sel`=0; hence `rdy_out`=1.
- Latency: input accepted at edge k appears with `ena_out`=1 after edge k+3 when unstalled. Throughput is 1 coefficient/cycle.
- While `ena_out && !rdy_in`: `out`, `out_idx` and `out_last` hold stable, `rdy_out`=0, and no input is accepted.
- Reset mid-stream drops all in-flight data immediately and the next accepted input is index 0.
- A table write at edge k is visible to a read at edge k+1 or later.

## Test plan
- Load table 0 with 4096 everywhere (Q=16); accept `in`=1200 at index 0 with `rdy_in`=1 -> `ena_out` rises 3 edges later with `out`=75, `out_idx`=0, `out_last`=0.
- Same table; inputs 1208, -1208, 8, -7, 0 -> outputs 76, -76, 1, 0, 0.
- Table 0 entry 0 = 65535; inputs 16383 and -16384 -> 1023 and -1023 (saturated).
- Stream 8 values 1..8 x 16 with `rdy_in` low for 5 cycles after the 2nd output -> outputs 1..8 in order, none lost or duplicated; `rdy_out` low exactly while `ena_out && !rdy_in`; held output stable.
- Table 1 all 2048 (Q=32), `tbl_sel`=1 at index 0, toggle `tbl_sel` mid-block, feed 64 x 320 -> all outputs 10; `out_last` only on the 64th; next block with `tbl_sel`=0 gives 20.
- Assert `rst` low mid-block with 3 items in flight -> `ena_out` drops without waiting for an edge; after release, first output has `out_idx`=0 and table contents are unchanged.
